// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD display.
// 7-seg patterns are {g,f,e,d,c,b,a}, active-low.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_display_if.sv
// Start/busy/done request bundle between a client and bin2bcd_seq_display.
// master drives start/bin; slave returns status and the result.
interface bin2bcd_seq_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   hex;

    modport master (
        output start, bin,
        input  busy, done, ovf, bcd, hex
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, bcd, hex
    );
endinterface

// File: rtl/bin2bcd_seq_display_seg7_decode.sv
// One BCD digit to an active-low 7-segment pattern.
// Codes above 9 show blank.
module seg7_decode
    import bin2bcd_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_bcd < 4'd10) o_seg = SEG_DIGIT[i_bcd];
    end

endmodule

// File: rtl/bin2bcd_seq_display.sv
// Sequential double-dabble binary to BCD converter with 7-seg outputs.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the MSD.
module bin2bcd_seq_display
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bin2bcd_seq_display_if.slave   bus
);

    localparam int          CW    = $clog2(WIDTH + 1);
    localparam int          BW    = 4 * DIGITS;
    localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_shift;
    logic [BW-1:0]       r_scr;
    logic [CW-1:0]       r_cnt;
    logic                r_ovf_nxt;
    logic                r_ovf;
    logic                r_done;
    logic [BW-1:0]       r_bcd;
    logic [7*DIGITS-1:0] r_hex;
    logic [BW-1:0]       w_adj;
    logic [7*DIGITS-1:0] w_seg;
    logic [7*DIGITS-1:0] w_hex;
    logic                w_ovf;

    assign w_ovf = (64'(bus.bin) > LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == CW'(1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied before every shift
    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scr[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_decode u_seg (
            .i_bcd (r_scr[4*g +: 4]),
            .o_seg (w_seg[7*g +: 7])
        );
    end

    always_comb begin
        w_hex = w_seg;
        if (r_ovf_nxt) begin
            w_hex = {DIGITS{SEG_MINUS}};
        end
`ifdef LEADING_ZERO_BLANK_EN
        else begin
            logic w_zero;
            w_zero = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                w_zero = w_zero & (r_scr[4*i +: 4] == 4'd0);
                if (w_zero) w_hex[7*i +: 7] = SEG_BLANK;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_scr     <= '0;
            r_cnt     <= '0;
            r_ovf_nxt <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_hex     <= {DIGITS{SEG_DIGIT[0]}};
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift   <= bus.bin;
                        r_scr     <= '0;
                        r_cnt     <= CW'(WIDTH);
                        r_ovf_nxt <= w_ovf;
                    end
                end
                SHIFT: begin
                    {r_scr, r_shift} <= {w_adj, r_shift} << 1;
                    r_cnt            <= r_cnt - CW'(1);
                end
                DONE: begin
                    r_bcd  <= r_scr;
                    r_hex  <= w_hex;
                    r_ovf  <= r_ovf_nxt;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.bcd  = r_bcd;
    assign bus.hex  = r_hex;

endmodule

// File: doc/bin2bcd_seq_display.md
Name: bin2bcd_seq_display

Overview:
- Parametrised, sequential successor to the combinational three-digit decimal display.
- Converts an unsigned binary word into DIGITS BCD digits using iterative shift-add-3 (double dabble), one bit per clock.
- Drives one active-low 7-segment output per digit.
- Sits between datapath/counter logic and the board HEX displays; a start/busy/done handshake replaces divide/modulo logic.

Parameters:
- WIDTH, 8, binary input width (>=1).
- DIGITS, 3, number of BCD digits and 7-seg outputs (>=1).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a conversion of bin; honoured only in IDLE.
- bin  input  WIDTH  unsigned value, sampled on the clk edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/hex/ovf are updated.
- ovf  output  1  sampled bin > 10^DIGITS-1; held with the result.
- bcd  output  4*DIGITS  packed digits, digit 0 (ones) in [3:0].
- hex  output  7*DIGITS  segment patterns, digit i in [7i+6:7i]; bit order {g,f,e,d,c,b,a}; active-low.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; busy=0, done=0, ovf=0, bcd=0.
  - Every hex digit = 7'b1000000 ("0").
  - Reset mid-conversion aborts it with no done pulse.
- IDLE:
  - start=1 at edge E: latch bin into the shift register, clear the BCD scratch, set the bit counter to WIDTH.
  - Compute ovf_next = (bin > 10^DIGITS-1); the localparam is computed at elaboration.
  - Go to SHIFT; busy=1 from E.
- SHIFT:
  - Each cycle: every scratch digit >=5 gets +3, then {scratch,shift} shifts left by 1. The counter decrements.
  - After WIDTH shift cycles (edges E+1..E+WIDTH), go to DONE.
- DONE (one cycle, entered at edge E+WIDTH):
  - At edge E+WIDTH+1, register bcd, hex and ovf, pulse done=1 for exactly that cycle, set busy=0, return to IDLE.
  - Latency from the start edge to the done edge is WIDTH+1 cycles.
  - The earliest next accepted start is the same cycle done is high, because state is IDLE.
- start while busy is ignored, with no queuing. bin changes during a conversion have no effect.
- Outputs hold the last result between conversions and change only on the done edge.
- Overflow: when ovf=1, bcd holds the truncated low DIGITS digits. Every hex digit shows minus (7'b0111111).
- Segment map, hex digits 0-9:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Non-BCD codes show blank (1111111); these are unreachable.
- Scratch register width is 4*DIGITS. Bits shifted beyond the top digit are discarded (overflow is covered by ovf).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when ovf=0, each zero digit above the most significant non-zero digit shows blank (1111111). Digit 0 is always shown, so value 0 shows a single "0". bcd is unaffected.
- Undefined: all DIGITS digits are always shown, including leading zeros.

Decomposition:
- Shared package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - 7-seg constants SEG_DIGIT[0:9], SEG_BLANK, SEG_MINUS.
  - Function pow10(n) for the overflow limit.
- One sub-module: seg7_decode (4-bit BCD in, 7-bit active-low out), instantiated DIGITS times via generate.
- The control FSM and double-dabble datapath stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-conversion of bin=200 -> busy=0, done never pulses, bcd=0x000, all hex=1000000.
- Default params, bin=255, start 1 cycle -> busy high 9 cycles; done pulses at edge start+9 with bcd=0x255, hex2=0100100, hex1=0010010, hex0=0010010, ovf=0.
- bin=0 then bin=9 back-to-back, second start issued in the done cycle -> bcd=0x000 then 0x009; no lost or extra done pulses.
- start pulsed again at cycle 3 of a busy conversion, with bin changed to 17 -> ignored; result still reflects the original bin=123 (bcd=0x123).
- WIDTH=10, DIGITS=3: bin=999 -> bcd=0x999, ovf=0; bin=1000 -> ovf=1, all hex=0111111, done at start+11.
- With LEADING_ZERO_BLANK_EN, bin=7 -> hex2=hex1=1111111, hex0=1111000; bin=0 -> only hex0=1000000 lit.
